// File: rtl/io_controller_pkg.sv
// Shared definitions for the CPU I/O controller: FSM state encoding and timing defaults.
package io_controller_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

    typedef enum logic [2:0] {
        ST_IDLE            = 3'd0,
        ST_OUT_WRITE       = 3'd1,
        ST_IN_WAIT_PRESS   = 3'd2,
        ST_IN_CAPTURE      = 3'd3,
        ST_IN_WAIT_RELEASE = 3'd4,
        ST_DONE            = 3'd5
    } io_state_t;

    function automatic logic state_stalls(input io_state_t s);
        return (s == ST_OUT_WRITE) || (s == ST_IN_WAIT_PRESS) ||
               (s == ST_IN_CAPTURE) || (s == ST_IN_WAIT_RELEASE);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces the confirm button; level plus a one-cycle press pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES; no backpressure (free-running sampler).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_0;
    logic             sync_1;
    logic [CNT_W-1:0] count;

    // Counter tracks consecutive cycles the synchronized level disagrees with the output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
            count  <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_0 <= button_raw;
            sync_1 <= sync_0;
            press  <= 1'b0;
            if (sync_1 == level) begin
                count <= '0;
            end else if (count == LAST_COUNT) begin
                count <= '0;
                level <= sync_1;
                press <= sync_1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/io_controller.sv
// Sequences CPU OUT/IN instructions against a display strobe and a debounced confirm button.
// Latency: OUT 2 cycles to io_done; IN waits for press and release. Backpressure: cpu_stall while busy.
module io_controller
    import io_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic out_req,
    input  logic in_req,
    input  logic button_raw,
    output logic write_enabled,
    output logic input_ready,
    output logic cpu_stall,
    output logic io_done,
    output logic waiting_input
);

    io_state_t state;
    io_state_t next_state;
    logic      btn_level;
    logic      btn_press;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_button_debouncer (
        .clock     (clock),
        .reset     (reset),
        .button_raw(button_raw),
        .level     (btn_level),
        .press     (btn_press)
    );

    // OUT wins a simultaneous request; a still-held IN is picked up on the next IDLE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (out_req)     next_state = ST_OUT_WRITE;
                else if (in_req) next_state = ST_IN_WAIT_PRESS;
            end
            ST_OUT_WRITE:       next_state = ST_DONE;
            ST_IN_WAIT_PRESS:   if (btn_press) next_state = ST_IN_CAPTURE;
            ST_IN_CAPTURE:      next_state = ST_IN_WAIT_RELEASE;
            ST_IN_WAIT_RELEASE: if (!btn_level) next_state = ST_DONE;
            ST_DONE:            next_state = ST_IDLE;
            default:            next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from next_state so they align exactly with the state they belong to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            write_enabled <= 1'b0;
            input_ready   <= 1'b0;
            cpu_stall     <= 1'b0;
            io_done       <= 1'b0;
            waiting_input <= 1'b0;
        end else begin
            state         <= next_state;
            write_enabled <= (next_state == ST_OUT_WRITE);
            input_ready   <= (next_state == ST_IN_CAPTURE);
            cpu_stall     <= state_stalls(next_state);
            io_done       <= (next_state == ST_DONE);
            waiting_input <= (next_state == ST_IN_WAIT_PRESS);
        end
    end

endmodule

// File: doc/io_controller.md
IO_CONTROLLER -- requirements
Module: io_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive clock cycles the synchronized button level must hold before the debounced level changes.
REQ-002 Parameter CNT_W, default 16, debounce counter width; must satisfy DEBOUNCE_CYCLES < 2**CNT_W.
REQ-003 clock  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 out_req  input  1  CPU OUT instruction request; level, held until io_done.
REQ-006 in_req  input  1  CPU IN instruction request; level, held until io_done.
REQ-007 button_raw  input  1  raw, asynchronous, bouncing "input confirm" push-button, active-high.
REQ-008 write_enabled  output  1  one-cycle strobe to the output/display register.
REQ-009 input_ready  output  1  one-cycle capture strobe to the switch input register.
REQ-010 cpu_stall  output  1  holds the CPU while an I/O operation is in progress.
REQ-011 io_done  output  1  one-cycle completion pulse to the CPU.
REQ-012 waiting_input  output  1  LED drive, high while waiting for the user to press.

Function
REQ-013 Button path: 2-flop synchronizer, then debouncer; debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion clears the counter.
REQ-014 Press event = debounced rising edge (one cycle); release = debounced level low.
REQ-015 FSM states: IDLE, OUT_WRITE, IN_WAIT_PRESS, IN_CAPTURE, IN_WAIT_RELEASE, DONE; all outputs registered or decoded from state only.
REQ-016 IDLE: out_req -> OUT_WRITE; else in_req -> IN_WAIT_PRESS; else stay.
REQ-017 out_req and in_req both high in IDLE: OUT served first; in_req is served on a later IDLE visit if still held.
REQ-018 OUT_WRITE: write_enabled=1 for exactly this cycle; next state DONE.
REQ-019 IN_WAIT_PRESS: waiting_input=1; on press event -> IN_CAPTURE.
REQ-020 IN_CAPTURE: input_ready=1 for exactly this cycle; next state IN_WAIT_RELEASE.
REQ-021 IN_WAIT_RELEASE: stay until debounced level low, then DONE; prevents one press satisfying two IN instructions.
REQ-022 DONE: io_done=1 for exactly this cycle; next state IDLE; CPU drops its request at this edge.
REQ-023 cpu_stall=1 in OUT_WRITE, IN_WAIT_PRESS, IN_CAPTURE, IN_WAIT_RELEASE; 0 in IDLE and DONE.
REQ-024 Press events in IDLE, OUT_WRITE or DONE are ignored; a button already held when IN begins requires release and new press.
REQ-025 Requests deasserting mid-operation do not abort it; the operation completes through DONE.
REQ-026 Latency: OUT = 2 cycles from acceptance to io_done; IN = 2 sync + DEBOUNCE_CYCLES + FSM cycles after stable press, plus release time.

Reset
REQ-027 Reset asynchronously forces state IDLE, synchronizer flops 0, debounced level 0, counter 0, all outputs 0.
REQ-028 Reset mid-operation discards the operation; no write_enabled, input_ready or io_done pulse results from it after reset release.

Structure
REQ-029 State encoding (enumerated constants) and default DEBOUNCE_CYCLES belong in the shared processor package.
REQ-030 One sub-module: button_debouncer (synchronizer + counter + edge detect), outputs debounced level and press pulse.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-031 out_req=1 in IDLE -> write_enabled high 1 cycle next edge, io_done 1 cycle later, cpu_stall high exactly 1 cycle.
REQ-032 in_req=1, button bounces 1,0,1,0 every cycle then holds 1 for 10 cycles -> exactly one input_ready pulse; io_done only after button low >=4 cycles.
REQ-033 out_req=1 and in_req=1 together -> write_enabled, io_done, then (requests still held) IN sequence with waiting_input=1.
REQ-034 Button held high before in_req -> no input_ready until release then new press.
REQ-035 reset asserted during IN_WAIT_RELEASE -> all outputs 0 immediately; after release with no requests, no io_done within 20 cycles.
REQ-036 Two back-to-back IN requests with one long press -> second IN waits for a second press.
